// File: rtl/axi_inst_read_master_pkg.sv
// Shared types and AXI encodings for the instruction-fetch read master.
package axi_inst_read_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_inst_read_master_if.sv
// AXI4 AR and R channels between the fetch read master and the interconnect.
interface axi_inst_read_master_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_inst_read_master.sv
// Single-beat AXI4 read master: one fetch start pulse becomes one AR+R
// transaction returning a 32-bit instruction word and an error flag.
module axi_inst_read_master
  import axi_inst_read_master_pkg::*;
#(
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] AR_ID    = '0,
  parameter logic [31:0]     ERR_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        axi_start_i,
  input  logic [31:0] axi_addr_i,
  output logic        axi_done_o,
  output logic [31:0] axi_rdata_o,
  output logic        axi_err_o,
  output logic        axi_busy_o,
  axi_inst_read_master_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        beat_bad;

  // Any error response or malformed beat (wrong ID, not last) degrades to a NOP.
  assign beat_bad = resp_is_err(bus.rresp) || !bus.rlast || (bus.rid != AR_ID);

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (axi_start_i) begin
          if (axi_addr_i[1:0] == 2'b00) begin
            araddr_d  = {axi_addr_i[31:2], 2'b00};
            arvalid_d = 1'b1;
            state_d   = ST_AR;
          end else begin
            rdata_d = ERR_INST;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_AR: begin
        if (arvalid_q && bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (rready_q && bus.rvalid) begin
          rready_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_RESP;
          if (beat_bad) begin
            rdata_d = ERR_INST;
            err_d   = 1'b1;
          end else begin
            rdata_d = bus.rdata;
            err_d   = 1'b0;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.arid    = AR_ID;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = SIZE_4B;
  assign bus.arburst = BURST_INCR;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  assign axi_done_o  = done_q;
  assign axi_rdata_o = rdata_q;
  assign axi_err_o   = err_q;
  assign axi_busy_o  = (state_q != ST_IDLE);

endmodule
